// File: rtl/systolic_seq_ctrl.sv
// Sequencing FSM for one NxN output-stationary systolic matrix multiply: CLEAR, FEED, FLUSH, DRAIN, DONE.
// Optional stall input and freeze behaviour are compiled in when SYS_CTRL_STALL_EN is defined.
module systolic_seq_ctrl #(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef SYS_CTRL_STALL_EN
  input  logic          stall,
`endif
  output logic          busy,
  output logic          done,
  output logic          pe_clr,
  output logic          pe_en,
  output logic          feed_en,
  output logic [CW-1:0] feed_idx,
  output logic          out_valid,
  output logic [CW-1:0] out_row
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CW-1:0] FEED_LAST  = CW'(K - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 3);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          frozen;

`ifdef SYS_CTRL_STALL_EN
  // A stall never holds the FSM in IDLE, so a start is still accepted there.
  assign frozen = stall && (state != IDLE);
`else
  assign frozen = 1'b0;
`endif

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!frozen) begin
      unique case (state)
        IDLE: begin
          cnt_nx = '0;
          if (start) state_nx = CLEAR;
        end
        CLEAR: begin
          state_nx = FEED;
          cnt_nx   = '0;
        end
        FEED: begin
          if (cnt == FEED_LAST) begin
            state_nx = FLUSH;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state_nx = DRAIN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        DONE: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Moore decode; strobes are suppressed while frozen, indices keep showing the held counter.
  always_comb begin
    busy      = (state != IDLE);
    done      = 1'b0;
    pe_clr    = 1'b0;
    pe_en     = 1'b0;
    feed_en   = 1'b0;
    feed_idx  = '0;
    out_valid = 1'b0;
    out_row   = '0;
    unique case (state)
      CLEAR: pe_clr = !frozen;
      FEED: begin
        feed_en  = !frozen;
        pe_en    = !frozen;
        feed_idx = cnt;
      end
      FLUSH: pe_en = !frozen;
      DRAIN: begin
        out_valid = !frozen;
        out_row   = cnt;
      end
      DONE:    done = !frozen;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: N=4/K=4 and N=2/K=1 instances share stimulus; a run-position
// timeline predicts each cycle's outputs, queued at drive time and compared at the falling edge.
module tb_systolic_seq_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pe_clr;
    logic       pe_en;
    logic       feed_en;
    logic [7:0] feed_idx;
    logic       out_valid;
    logic [7:0] out_row;
  } obs_t;

  logic clk = 1'b0;
  logic rst, start, stall;

  logic       a_busy, a_done, a_pe_clr, a_pe_en, a_feed_en, a_out_valid;
  logic [7:0] a_feed_idx, a_out_row;
  logic       b_busy, b_done, b_pe_clr, b_pe_en, b_feed_en, b_out_valid;
  logic [7:0] b_feed_idx, b_out_row;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  obs_t q_a[$];
  obs_t q_b[$];

  int   pos_a = 0, pos_b = 0;
  logic prev_s = 1'b0, prev_r = 1'b1, prev_st = 1'b0;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.N(4), .K(4), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .start(start),
`ifdef SYS_CTRL_STALL_EN
    .stall(stall),
`endif
    .busy(a_busy), .done(a_done), .pe_clr(a_pe_clr), .pe_en(a_pe_en),
    .feed_en(a_feed_en), .feed_idx(a_feed_idx), .out_valid(a_out_valid), .out_row(a_out_row)
  );

  systolic_seq_ctrl #(.N(2), .K(1), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .start(start),
`ifdef SYS_CTRL_STALL_EN
    .stall(stall),
`endif
    .busy(b_busy), .done(b_done), .pe_clr(b_pe_clr), .pe_en(b_pe_en),
    .feed_en(b_feed_en), .feed_idx(b_feed_idx), .out_valid(b_out_valid), .out_row(b_out_row)
  );

  // pos = cycle number within a run (1 = CLEAR cycle), 0 = idle.
  function automatic obs_t exp_at(int pos, int n, int k, logic st);
    obs_t e;
    e = '0;
    if (pos == 0) return e;
    e.busy = 1'b1;
    if (pos == 1) e.pe_clr = 1'b1;
    else if (pos <= k + 1) begin
      e.feed_en  = 1'b1;
      e.pe_en    = 1'b1;
      e.feed_idx = 8'(pos - 2);
    end else if (pos <= k + 2 * n - 1) e.pe_en = 1'b1;
    else if (pos <= k + 3 * n - 1) begin
      e.out_valid = 1'b1;
      e.out_row   = 8'(pos - k - 2 * n);
    end else e.done = 1'b1;
    if (st) begin
      e.pe_clr    = 1'b0;
      e.pe_en     = 1'b0;
      e.feed_en   = 1'b0;
      e.out_valid = 1'b0;
      e.done      = 1'b0;
    end
    return e;
  endfunction

  function automatic int next_pos(int pos, int n, int k, logic s, logic r, logic st);
    if (r) return 0;
    if (pos == 0) return s ? 1 : 0;
    if (st) return pos;
    if (pos == k + 3 * n) return 0;
    return pos + 1;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue that cycle's expected outputs.
  task automatic cyc(input logic s, input logic r, input logic st);
    @(posedge clk);
    #1;
    cycle = cycle + 1;
    pos_a = next_pos(pos_a, 4, 4, prev_s, prev_r, prev_st);
    pos_b = next_pos(pos_b, 2, 1, prev_s, prev_r, prev_st);
    start = s;
    rst   = r;
    stall = st;
    prev_s  = s;
    prev_r  = r;
    prev_st = st;
    q_a.push_back(exp_at(pos_a, 4, 4, st));
    q_b.push_back(exp_at(pos_b, 2, 1, st));
  endtask

  always @(negedge clk) begin
    obs_t o, e;
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      o = {a_busy, a_done, a_pe_clr, a_pe_en, a_feed_en, a_feed_idx, a_out_valid, a_out_row};
      checks = checks + 1;
      assert (o === e) else begin
        failures = failures + 1;
        $error("FAIL n4k4 cycle=%0d observed=%h expected=%h", cycle, o, e);
      end
      checks = checks + 1;
      assert ($onehot0({a_pe_clr, a_feed_en, a_out_valid, a_done}) === 1'b1) else begin
        failures = failures + 1;
        $error("FAIL n4k4_excl cycle=%0d observed=%b expected=onehot0", cycle,
               {a_pe_clr, a_feed_en, a_out_valid, a_done});
      end
    end
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      o = {b_busy, b_done, b_pe_clr, b_pe_en, b_feed_en, b_feed_idx, b_out_valid, b_out_row};
      checks = checks + 1;
      assert (o === e) else begin
        failures = failures + 1;
        $error("FAIL n2k1 cycle=%0d observed=%h expected=%h", cycle, o, e);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;

    // Reset held for two cycles, then idle.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0);

    // Single-cycle start: done at cycle 16 (N=4,K=4) and cycle 7 (N=2,K=1).
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) cyc(1'b0, 1'b0, 1'b0);

    // Start held for 40 cycles: back-to-back runs, mid-run start ignored.
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0);

    // Reset asserted in cycle 8 of a run aborts it; a fresh run then completes.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) cyc(1'b0, 1'b0, 1'b0);

`ifdef SYS_CTRL_STALL_EN
    // Stall in IDLE does not block start; 3-cycle stall at feed_idx=2 delays done to cycle 19.
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b0);
    // Stall over the DONE cycle of the N=4 instance stretches it.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
`endif

    @(negedge clk);
    #1;
    checks = checks + 1;
    assert ((q_a.size() + q_b.size()) === 0) else begin
      failures = failures + 1;
      $error("FAIL drain observed=%0d expected=0", q_a.size() + q_b.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
